// File: rtl/ram_fifo_pkg.sv
// Shared sizing helpers for the RAM-backed FWFT FIFO controller.
// Pointers carry one extra wrap bit; the level count spans 0..2**DEPTH_LOG2+1.
package ram_fifo_pkg;

    function automatic int PTR_W(input int depth_log2);
        return depth_log2 + 1;
    endfunction

    function automatic int LVL_W(input int depth_log2);
        return depth_log2 + 2;
    endfunction

endpackage

// File: rtl/ram_fifo_out_stage.sv
// Output register of the FIFO: loads the RAM head word when empty or being consumed, one-cycle load latency.
// Holds out_data stable while out_valid && !out_ready; load strobe tells the pointer logic to advance rptr.
module ram_fifo_out_stage #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ram_empty,
    input  logic [DATA_WIDTH-1:0] rd_data,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    output logic                  load
);

    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_valid;

    assign load      = !ram_empty && (!r_valid || out_ready);
    assign out_data  = r_data;
    assign out_valid = r_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_data  <= '0;
            r_valid <= 1'b0;
        end else if (load) begin
            r_data  <= rd_data;
            r_valid <= 1'b1;
        end else if (r_valid && out_ready) begin
            // RAM is empty here, so the register drains and keeps its last word
            r_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/ram_fifo_ctrl.sv
// Pointer/flow-control front end for a dual-port RAM forming a FWFT FIFO; 2 edges in-to-out, 1 word/cycle.
// in_ready depends only on registered pointers and reset; optional level/almost_full via RAM_FIFO_LEVEL_EN.
module ram_fifo_ctrl
    import ram_fifo_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int DEPTH_LOG2   = 4,
    parameter int AFULL_THRESH = 12
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [DATA_WIDTH-1:0]          in_data,
    input  logic                           in_valid,
    output logic                           in_ready,
    output logic [DATA_WIDTH-1:0]          out_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [DATA_WIDTH-1:0]          ram_wr_data,
    output logic [DEPTH_LOG2-1:0]          ram_wr_addr,
    output logic                           ram_wr_en,
    output logic [DEPTH_LOG2-1:0]          ram_rd_addr,
    input  logic [DATA_WIDTH-1:0]          ram_rd_data,
    output logic [LVL_W(DEPTH_LOG2)-1:0]   level,
    output logic                           almost_full
);

    localparam int PW = PTR_W(DEPTH_LOG2);
    localparam int LW = LVL_W(DEPTH_LOG2);

    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic          w_ram_empty;
    logic          w_ram_full;
    logic          w_wr;
    logic          w_load;

    // Empty is a compare of registered pointers, so a word is never read in its write cycle
    assign w_ram_empty = (r_wptr == r_rptr);
    assign w_ram_full  = (r_wptr[PW-1] != r_rptr[PW-1]) &&
                         (r_wptr[PW-2:0] == r_rptr[PW-2:0]);

    assign in_ready    = !w_ram_full && !reset;
    assign w_wr        = in_valid && in_ready;
    assign ram_wr_en   = w_wr;
    assign ram_wr_addr = r_wptr[DEPTH_LOG2-1:0];
    assign ram_wr_data = in_data;
    assign ram_rd_addr = r_rptr[DEPTH_LOG2-1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_wr)
                r_wptr <= r_wptr + 1'b1;
            if (w_load)
                r_rptr <= r_rptr + 1'b1;
        end
    end

    ram_fifo_out_stage #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_out_stage (
        .clk       (clk),
        .reset     (reset),
        .ram_empty (w_ram_empty),
        .rd_data   (ram_rd_data),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .load      (w_load)
    );

`ifdef RAM_FIFO_LEVEL_EN
    logic [LW-1:0] r_level;
    logic [LW-1:0] w_level_nxt;
    logic          r_afull;
    logic          w_pop;

    assign w_pop = out_valid && out_ready;

    always_comb begin
        w_level_nxt = r_level;
        if (w_wr && !w_pop)
            w_level_nxt = r_level + 1'b1;
        else if (!w_wr && w_pop)
            w_level_nxt = r_level - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_level <= '0;
            r_afull <= 1'b0;
        end else begin
            r_level <= w_level_nxt;
            r_afull <= (int'(w_level_nxt) >= AFULL_THRESH);
        end
    end

    assign level       = r_level;
    assign almost_full = r_afull;
`else
    assign level       = {LW{1'b0}};
    // Threshold has no meaning without the counter; output is tied low
    assign almost_full = 1'b0 && (AFULL_THRESH != 0);
`endif

endmodule
